fpmul_norm_round: RTL and testbench

FPMUL_NORM_ROUND -- requirements
Module: fpmul_norm_round

---
 rtl/fpmul_norm_round.sv | 198 +++++++++++++++++++
 tb/tb_fpmul_norm_round.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_norm_round.sv
// fpmul_norm_round: two-stage normalize/round/pack back end of an FP32 multiplier.
// Ports: clk, rst (sync, active-high), en (advance), clear[num_rds] (per-stage flush),
//   product in (sign_i, exp_i, mant_i), class bits, rm_i, sideband in (P_signal_i,
//   pipeline_signals_i); out: result_o, fflags_o {NV,DZ,OF,UF,NX}, P_O_signal,
//   pipeline_signals_o, uu_rd / uu_reg_write / uu_FP_reg_write (index 1 = stage 1).

package fpmul_norm_round_pkg;
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       FP_reg_write;
    } exe_p_mux_bus_type;
endpackage

module fpmul_norm_round
    import fpmul_norm_round_pkg::*;
#(
    parameter int addr_width = 5,
    parameter int num_rds    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [num_rds-1:0]                   clear,
    input  logic                                 sign_i,
    input  logic [9:0]                           exp_i,
    input  logic [47:0]                          mant_i,
    input  logic                                 is_NaN_i,
    input  logic                                 is_inf_i,
    input  logic                                 is_zero_i,
    input  logic                                 invalid_i,
    input  logic [2:0]                           rm_i,
    input  logic                                 P_signal_i,
    input  exe_p_mux_bus_type                    pipeline_signals_i,
    output logic [31:0]                          result_o,
    output logic [4:0]                           fflags_o,
    output logic                                 P_O_signal,
    output exe_p_mux_bus_type                    pipeline_signals_o,
    output logic [num_rds-1:0][addr_width-1:0]   uu_rd,
    output logic [num_rds-1:0]                   uu_reg_write,
    output logic [num_rds-1:0]                   uu_FP_reg_write
);

    typedef struct packed {
        logic              sign;
        logic [9:0]        e;
        logic [23:0]       sig;
        logic              g;
        logic              r;
        logic              s;
        logic [2:0]        rm;
        logic              nan;
        logic              inf;
        logic              zero;
        logic              inv;
        logic              p;
        exe_p_mux_bus_type side;
    } s1_t;

    typedef struct packed {
        logic [31:0]       res;
        logic [4:0]        fl;
        logic              p;
        exe_p_mux_bus_type side;
    } s2_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    // ---------------- stage 1: normalize ----------------
    logic [5:0]  lz;
    logic [11:0] e_x, e_n;
    logic [46:0] x, xs;
    logic        st0, lost;
    logic [5:0]  sh;
    logic [93:0] wide;
    logic [9:0]  e1;

    always_comb begin
        lz = 6'd47;
        for (int i = 0; i < 46; i++)
            if (mant_i[i]) lz = 6'(46 - i);
        e_x = {{2{exp_i[9]}}, exp_i};
        st0 = 1'b0;
        x   = mant_i[46:0];
        e_n = e_x;
        if (mant_i[47]) begin
            x   = mant_i[47:1];
            st0 = mant_i[0];
            e_n = e_x + 12'd1;
        end else if (!mant_i[46]) begin
            x   = 47'(mant_i << lz);
            e_n = e_x - {6'd0, lz};
        end
        // E<=0: denormalize; a 47-bit shift clears everything into sticky
        sh = 6'd0;
        e1 = e_n[9:0];
        if ($signed(e_n) <= 12'sd0) begin
            e1 = 10'd0;
            if ($signed(e_n) < -12'sd46) sh = 6'd47;
            else                         sh = 6'(12'd1 - e_n);
        end else if ($signed(e_n) > 12'sd511) begin
            e1 = 10'd511;
        end
        wide = {x, 47'd0} >> sh;
        xs   = wide[93:47];
        lost = |wide[46:0];

        s1_d      = '0;
        s1_d.sign = sign_i;
        s1_d.e    = e1;
        s1_d.sig  = xs[46:23];
        s1_d.g    = xs[22];
        s1_d.r    = xs[21];
        s1_d.s    = (|xs[20:0]) | lost | st0;
        s1_d.rm   = rm_i;
        s1_d.nan  = is_NaN_i;
        s1_d.inf  = is_inf_i;
        s1_d.zero = is_zero_i;
        s1_d.inv  = invalid_i;
        s1_d.p    = P_signal_i;
        s1_d.side = pipeline_signals_i;
    end

    always_ff @(posedge clk) begin
        if (rst || clear[1]) s1_q <= '0;
        else if (en)         s1_q <= s1_d;
    end

    // ---------------- stage 2: round and pack ----------------
    logic [2:0]  rm_e;
    logic        inc, grs;
    logic [24:0] sum;
    logic [22:0] frac;
    logic [10:0] er;

    always_comb begin
        rm_e = (s1_q.rm > 3'd4) ? 3'd0 : s1_q.rm;
        grs  = s1_q.g | s1_q.r | s1_q.s;
        case (rm_e)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s1_q.sign & grs;
            3'd3:    inc = ~s1_q.sign & grs;
            3'd4:    inc = s1_q.g;
            default: inc = s1_q.g & (s1_q.r | s1_q.s | s1_q.sig[0]);
        endcase
        sum  = {1'b0, s1_q.sig} + 25'(inc);
        frac = sum[24] ? sum[23:1] : sum[22:0];
        er   = {1'b0, s1_q.e} + 11'(sum[24]);
        // a subnormal rounding into the hidden bit becomes the smallest normal
        if (s1_q.e == 10'd0 && sum[23]) er = 11'd1;

        s2_d      = '0;
        s2_d.p    = s1_q.p;
        s2_d.side = s1_q.side;
        s2_d.res  = {s1_q.sign, er[7:0], frac};
        s2_d.fl   = {3'b000, grs & (er[7:0] == 8'd0), grs};
        if (er >= 11'd255) begin
            s2_d.fl = 5'b00101;
            case (rm_e)
                3'd1:    s2_d.res = {s1_q.sign, 31'h7F7FFFFF};
                3'd2:    s2_d.res = s1_q.sign ? 32'hFF800000 : 32'h7F7FFFFF;
                3'd3:    s2_d.res = s1_q.sign ? 32'hFF7FFFFF : 32'h7F800000;
                default: s2_d.res = {s1_q.sign, 8'hFF, 23'd0};
            endcase
        end
        if (s1_q.zero) begin
            s2_d.res = {s1_q.sign, 31'd0};
            s2_d.fl  = 5'd0;
        end
        if (s1_q.inf) begin
            s2_d.res = {s1_q.sign, 8'hFF, 23'd0};
            s2_d.fl  = 5'd0;
        end
        if (s1_q.nan) begin
            s2_d.res = 32'h7FC00000;
            s2_d.fl  = {s1_q.inv, 4'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear[0]) s2_q <= '0;
        else if (en)         s2_q <= s2_d;
    end

    assign result_o           = s2_q.res;
    assign fflags_o           = s2_q.fl;
    assign P_O_signal         = s2_q.p;
    assign pipeline_signals_o = s2_q.side;

    assign uu_rd[1]           = addr_width'(s1_q.side.rd);
    assign uu_rd[0]           = addr_width'(s2_q.side.rd);
    assign uu_reg_write[1]    = s1_q.side.reg_write;
    assign uu_reg_write[0]    = s2_q.side.reg_write;
    assign uu_FP_reg_write[1] = s1_q.side.FP_reg_write;
    assign uu_FP_reg_write[0] = s2_q.side.FP_reg_write;

endmodule

// File: tb/tb_fpmul_norm_round.sv
// tb_fpmul_norm_round: directed and random checks of fpmul_norm_round against
// a value-level FP32 rounding model and a two-slot pipeline model.

module tb_fpmul_norm_round;
    import fpmul_norm_round_pkg::*;

    logic clk = 1'b0;
    logic rst, en;
    logic [1:0] clear;
    logic sign_i;
    logic [9:0] exp_i;
    logic [47:0] mant_i;
    logic is_NaN_i, is_inf_i, is_zero_i, invalid_i;
    logic [2:0] rm_i;
    logic P_signal_i;
    exe_p_mux_bus_type pipeline_signals_i;
    logic [31:0] result_o;
    logic [4:0] fflags_o;
    logic P_O_signal;
    exe_p_mux_bus_type pipeline_signals_o;
    logic [1:0][4:0] uu_rd;
    logic [1:0] uu_reg_write, uu_FP_reg_write;

    int checks = 0;
    int failures = 0;

    fpmul_norm_round dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
        .is_NaN_i(is_NaN_i), .is_inf_i(is_inf_i), .is_zero_i(is_zero_i),
        .invalid_i(invalid_i), .rm_i(rm_i), .P_signal_i(P_signal_i),
        .pipeline_signals_i(pipeline_signals_i),
        .result_o(result_o), .fflags_o(fflags_o), .P_O_signal(P_O_signal),
        .pipeline_signals_o(pipeline_signals_o), .uu_rd(uu_rd),
        .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       res;
        logic [4:0]        fl;
        logic              p;
        exe_p_mux_bus_type side;
    } slot_t;

    slot_t m1, m2;

    // value = mant * 2^(exp-127-46), rounded to FP32 by remainder comparison
    function automatic logic [36:0] ref_fp(
        input logic s, input logic [9:0] ex, input logic [47:0] m,
        input logic [2:0] rm, input logic nan, input logic inf,
        input logic zer, input logic inv);
        int p, e, k, biased;
        logic [127:0] q, rem, half, mm;
        logic inc, nx;
        logic [2:0] r;
        logic [7:0] bx;
        if (nan) return {32'h7FC00000, inv, 4'd0};
        if (inf) return {s, 8'hFF, 23'd0, 5'd0};
        if (zer) return {s, 31'd0, 5'd0};
        r = (rm > 3'd4) ? 3'd0 : rm;
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        e = int'($signed(ex)) + p - 46;
        k = p - 23 + ((e < 1) ? 1 - e : 0);
        if (k > 100) k = 100;
        mm = 128'(m);
        if (k <= 0) begin
            q = mm << (-k); rem = '0; half = '0;
        end else begin
            q = mm >> k; rem = mm - (q << k); half = 128'(1) << (k - 1);
        end
        nx = (rem != 0);
        case (r)
            3'd1: inc = 1'b0;
            3'd2: inc = s && nx;
            3'd3: inc = !s && nx;
            3'd4: inc = (half != 0) && (rem >= half);
            default: inc = (rem > half) || (rem == half && half != 0 && q[0]);
        endcase
        q = q + 128'(inc);
        if (e >= 1) begin
            biased = e;
            if (q[24]) begin q = q >> 1; biased++; end
        end else begin
            biased = q[23] ? 1 : 0;
        end
        if (biased >= 255) begin
            case (r)
                3'd1: return {s, 31'h7F7FFFFF, 5'b00101};
                3'd2: return {(s ? 32'hFF800000 : 32'h7F7FFFFF), 5'b00101};
                3'd3: return {(s ? 32'hFF7FFFFF : 32'h7F800000), 5'b00101};
                default: return {s, 8'hFF, 23'd0, 5'b00101};
            endcase
        end
        bx = 8'(biased);
        return {s, bx, q[22:0], 3'b000, nx && (bx == 8'd0), nx};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("result", result_o, m2.res);
        check("fflags", 32'(fflags_o), 32'(m2.fl));
        check("p_out", 32'(P_O_signal), 32'(m2.p));
        check("side_out", 32'(pipeline_signals_o), 32'(m2.side));
        check("uu_rd1", 32'(uu_rd[1]), 32'(m1.side.rd));
        check("uu_rd0", 32'(uu_rd[0]), 32'(m2.side.rd));
        check("uu_rw", 32'(uu_reg_write),
              32'({m1.side.reg_write, m2.side.reg_write}));
        check("uu_fprw", 32'(uu_FP_reg_write),
              32'({m1.side.FP_reg_write, m2.side.FP_reg_write}));
    endtask

    task automatic step();
        slot_t nxt;
        {nxt.res, nxt.fl} = ref_fp(sign_i, exp_i, mant_i, rm_i, is_NaN_i,
                                   is_inf_i, is_zero_i, invalid_i);
        nxt.p = P_signal_i;
        nxt.side = pipeline_signals_i;
        if (rst) begin
            m1 = '0; m2 = '0;
        end else begin
            if (clear[0]) m2 = '0; else if (en) m2 = m1;
            if (clear[1]) m1 = '0; else if (en) m1 = nxt;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic set_op(input logic s, input logic [9:0] ex,
                          input logic [47:0] m, input logic [2:0] rm,
                          input logic [3:0] cls);
        sign_i = s; exp_i = ex; mant_i = m; rm_i = rm;
        {is_NaN_i, is_inf_i, is_zero_i, invalid_i} = cls;
        P_signal_i = 1'($urandom);
        pipeline_signals_i = 7'($urandom);
    endtask

    localparam int ND = 13;
    logic        d_s   [ND] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1};
    logic [9:0]  d_e   [ND] = '{128, 300, 300, 10'h3F6, 10'h3F6, 0, 0,
                                300, 300, 300, 127, 0, 0};
    logic [47:0] d_m   [ND] = '{48'h600000000000, 48'h400000000000,
                                48'h400000000000, 48'h400000000000,
                                48'h400000000001, 48'h1, 48'h1,
                                48'h400000000000, 48'h400000000000,
                                48'h400000000000, 48'h7FFFFFFFFFFF,
                                48'h7FFFFFFFFFFF, 48'h1};
    logic [2:0]  d_rm  [ND] = '{0, 1, 0, 0, 0, 0, 0, 5, 2, 3, 0, 0, 0};
    logic [3:0]  d_cls [ND] = '{0, 0, 0, 0, 0, 4'b1001, 4'b0100,
                                0, 0, 0, 0, 0, 4'b0010};
    logic [31:0] d_res [ND] = '{32'h40400000, 32'h7F7FFFFF, 32'h7F800000,
                                32'h00001000, 32'h00001000, 32'h7FC00000,
                                32'hFF800000, 32'h7F800000, 32'hFF800000,
                                32'hFF7FFFFF, 32'h40000000, 32'h00800000,
                                32'h80000000};
    logic [4:0]  d_fl  [ND] = '{5'h00, 5'h05, 5'h05, 5'h00, 5'h03, 5'h10,
                                5'h00, 5'h05, 5'h05, 5'h05, 5'h01, 5'h01,
                                5'h00};

    initial begin
        m1 = '0; m2 = '0;
        rst = 1'b1; en = 1'b1; clear = 2'b00;
        set_op(0, 0, 48'h1, 0, 0);
        step();
        step();
        check("reset_result", result_o, 32'd0);
        check("reset_uu_rd", 32'(uu_rd), 32'd0);
        rst = 1'b0;

        // directed table, pipelined back-to-back
        for (int i = 0; i <= ND; i++) begin
            if (i < ND) set_op(d_s[i], d_e[i], d_m[i], d_rm[i], d_cls[i]);
            else        set_op(0, 127, 48'h400000000000, 0, 0);
            step();
            if (i >= 1) begin
                check($sformatf("dir%0d_res", i - 1), result_o, d_res[i - 1]);
                check($sformatf("dir%0d_fl", i - 1), 32'(fflags_o),
                      32'(d_fl[i - 1]));
            end
        end

        // stall, stage-2 flush, reset with both stages valid
        set_op(0, 128, 48'h600000000000, 0, 0);
        step();
        set_op(1, 130, 48'h500000000000, 0, 0);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        step();
        check("stall_release", result_o, 32'h40400000);
        set_op(0, 129, 48'h400000000000, 0, 0);
        clear = 2'b01;
        step();
        check("flush_res", result_o, 32'd0);
        check("flush_p", 32'(P_O_signal), 32'd0);
        clear = 2'b00;
        step();
        set_op(1, 126, 48'h480000000000, 1, 0);
        step();
        rst = 1'b1;
        step();
        check("rst_res", result_o, 32'd0);
        check("rst_uu_rw", 32'(uu_reg_write), 32'd0);
        rst = 1'b0;
        clear = 2'b11;
        step();
        clear = 2'b00;

        // random operations with random stalls and flushes
        for (int n = 0; n < 500; n++) begin
            logic [63:0] r64;
            logic [47:0] m;
            logic [3:0] cls;
            r64 = {$urandom, $urandom};
            m = 48'(r64) >> $urandom_range(0, 47);
            if (m == 48'd0) m = 48'd1;
            cls = 4'd0;
            case ($urandom_range(0, 15))
                0: cls = {3'b100, 1'($urandom)};
                1: cls = 4'b0100;
                2: cls = 4'b0010;
                default: cls = 4'd0;
            endcase
            set_op(1'($urandom), 10'($urandom_range(0, 410) - 80), m,
                   3'($urandom), cls);
            en = ($urandom_range(0, 7) != 0);
            clear[0] = ($urandom_range(0, 15) == 0);
            clear[1] = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
